// File: rtl/register_file_sb.sv
// Integer register file with hardwired-zero location 0, write-to-read bypass
// and a per-register busy scoreboard tracking in-flight writebacks.
module register_file_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  input  logic                flush_i,
  output logic [AW:0]         busy_cnt_o
);

  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]  regs_q [1:NREGS-1];
  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:1] busy_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned r = 1; r < NREGS; r++) begin
        regs_q[AW'(r)] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (wr_en_i && (wr_addr_i == AW'(r))) begin
          regs_q[AW'(r)] <= wr_data_i;
        end
      end
    end
  end

  // Flush beats issue; issue beats writeback clear (the newer producer wins).
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (flush_i) begin
        busy_d[AW'(r)] = 1'b0;
      end else if (iss_en_i && (iss_addr_i == AW'(r))) begin
        busy_d[AW'(r)] = 1'b1;
      end else if (wr_en_i && (wr_addr_i == AW'(r))) begin
        busy_d[AW'(r)] = 1'b0;
      end
    end
    for (int unsigned r = 1; r < NREGS; r++) begin
      cnt_d = cnt_d + CW'(busy_d[AW'(r)]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] stored;
    logic            stored_busy;
    logic            fwd;

    assign addr = rd_addr_i[k*AW +: AW];

    // Address 0 matches no entry, so it reads as zero and never busy.
    always_comb begin
      stored      = '0;
      stored_busy = 1'b0;
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (addr == AW'(r)) begin
          stored      = regs_q[AW'(r)];
          stored_busy = busy_q[AW'(r)];
        end
      end
    end

    assign fwd = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr) && (addr != '0);
    assign rd_data_o[k*XLEN +: XLEN] = fwd ? wr_data_i : stored;
    assign rd_busy_o[k]              = stored_busy & ~fwd;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: expectations are queued when stimulus
// is applied and popped against the DUT outputs once they have settled.
module tb_register_file_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]      rd_busy, rd_busy_nb;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic [AW:0]         busy_cnt, busy_cnt_nb;

  always #5 clk = ~clk;

  register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_busy_o(rd_busy), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .flush_i(flush), .busy_cnt_o(busy_cnt)
  );

  register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb),
    .rd_busy_o(rd_busy_nb), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .flush_i(flush), .busy_cnt_o(busy_cnt_nb)
  );

  typedef enum int { K_D0, K_D1, K_BUSY, K_CNT, K_NB_D0, K_NB_BUSY, K_NB_CNT } kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [31:0] observe(kind_t k);
    case (k)
      K_D0:      return rd_data[31:0];
      K_D1:      return rd_data[63:32];
      K_BUSY:    return 32'(rd_busy);
      K_CNT:     return 32'(busy_cnt);
      K_NB_D0:   return rd_data_nb[31:0];
      K_NB_BUSY: return 32'(rd_busy_nb);
      default:   return 32'(busy_cnt_nb);
    endcase
  endfunction

  task automatic expect_val(kind_t k, logic [31:0] v, string tag);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.kind);
      n_total++;
      assert (o === e.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; iss_en = 0; flush = 0;
  endtask

  task automatic issue(logic [AW-1:0] a);
    iss_en = 1; iss_addr = a;
    tick();
    iss_en = 0;
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0;
    iss_en = 0; iss_addr = '0; flush = 0; rd_addr = '0;
    @(negedge clk);
    tick();
    idle();

    // reset state
    rd_addr = {5'd0, 5'd5};
    expect_val(K_D0, 32'h0, "rst_d0");
    expect_val(K_D1, 32'h0, "rst_d1");
    expect_val(K_BUSY, 32'h0, "rst_busy");
    expect_val(K_CNT, 32'h0, "rst_cnt");
    check_all();

    // write with same-cycle bypass, both ports on the same address
    wr_en = 1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; rd_addr = {5'd7, 5'd7};
    expect_val(K_D0, 32'hDEADBEEF, "byp_d0");
    expect_val(K_D1, 32'hDEADBEEF, "byp_d1");
    expect_val(K_NB_D0, 32'h0, "nobyp_old");
    check_all();
    tick();
    idle();
    expect_val(K_D0, 32'hDEADBEEF, "wr_d0_next");
    expect_val(K_NB_D0, 32'hDEADBEEF, "nobyp_next");
    check_all();

    // register 0 immunity
    wr_en = 1; wr_addr = 5'd0; wr_data = 32'h12345678;
    iss_en = 1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    expect_val(K_D0, 32'h0, "x0_d0_same");
    expect_val(K_D1, 32'h0, "x0_d1_same");
    check_all();
    tick();
    idle();
    expect_val(K_D0, 32'h0, "x0_d0_next");
    expect_val(K_BUSY, 32'h0, "x0_busy");
    expect_val(K_CNT, 32'h0, "x0_cnt");
    check_all();

    // RAW scoreboard sequence
    issue(5'd3);
    rd_addr = {5'd4, 5'd3};
    expect_val(K_BUSY, 32'h1, "iss3_busy");
    expect_val(K_CNT, 32'h1, "iss3_cnt");
    expect_val(K_NB_BUSY, 32'h1, "iss3_nb_busy");
    check_all();
    issue(5'd4);
    expect_val(K_CNT, 32'h2, "iss4_cnt");
    expect_val(K_BUSY, 32'h3, "iss4_busy");
    check_all();
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'hA5;
    expect_val(K_BUSY, 32'h2, "wb3_busy_same");
    expect_val(K_D0, 32'hA5, "wb3_d0_same");
    expect_val(K_NB_BUSY, 32'h3, "wb3_nb_busy_same");
    expect_val(K_CNT, 32'h2, "wb3_cnt_same");
    check_all();
    tick();
    idle();
    expect_val(K_CNT, 32'h1, "wb3_cnt_next");
    expect_val(K_BUSY, 32'h2, "wb3_busy_next");
    expect_val(K_D0, 32'hA5, "wb3_d0_next");
    expect_val(K_NB_CNT, 32'h1, "wb3_nb_cnt");
    check_all();

    // simultaneous issue and writeback on a busy register
    issue(5'd9);
    rd_addr = {5'd4, 5'd9};
    iss_en = 1; iss_addr = 5'd9; wr_en = 1; wr_addr = 5'd9; wr_data = 32'h55;
    expect_val(K_BUSY, 32'h2, "sc9_busy_same");
    expect_val(K_D0, 32'h55, "sc9_d0_same");
    check_all();
    tick();
    idle();
    expect_val(K_BUSY, 32'h3, "sc9_busy_next");
    expect_val(K_D0, 32'h55, "sc9_d0_next");
    expect_val(K_CNT, 32'h2, "sc9_cnt");
    check_all();

    // flush with a same-cycle issue
    issue(5'd2); issue(5'd5); issue(5'd6); issue(5'd6);
    expect_val(K_CNT, 32'h5, "pre_flush_cnt");
    check_all();
    flush = 1; iss_en = 1; iss_addr = 5'd8;
    tick();
    idle();
    rd_addr = {5'd2, 5'd8};
    expect_val(K_CNT, 32'h0, "flush_cnt");
    expect_val(K_BUSY, 32'h0, "flush_busy");
    check_all();
    rd_addr = {5'd9, 5'd7};
    expect_val(K_D0, 32'hDEADBEEF, "flush_keep7");
    expect_val(K_D1, 32'h55, "flush_keep9");
    check_all();

    // writeback to a register that is not busy
    wr_en = 1; wr_addr = 5'd10; wr_data = 32'h77;
    tick();
    idle();
    rd_addr = {5'd10, 5'd7};
    expect_val(K_D1, 32'h77, "wb_idle_d1");
    expect_val(K_BUSY, 32'h0, "wb_idle_busy");
    expect_val(K_CNT, 32'h0, "wb_idle_cnt");
    check_all();

    // reset mid-operation, with an issue and a write in flight
    issue(5'd2); issue(5'd5); issue(5'd6);
    expect_val(K_CNT, 32'h3, "pre_rst_cnt");
    check_all();
    rst = 1; iss_en = 1; iss_addr = 5'd8; wr_en = 1; wr_addr = 5'd3; wr_data = 32'hFF;
    tick();
    idle();
    rd_addr = {5'd3, 5'd7};
    expect_val(K_CNT, 32'h0, "rst2_cnt");
    expect_val(K_BUSY, 32'h0, "rst2_busy");
    expect_val(K_D0, 32'h0, "rst2_d7");
    expect_val(K_D1, 32'h0, "rst2_d3");
    expect_val(K_NB_D0, 32'h0, "rst2_nb_d7");
    check_all();
    rd_addr = {5'd10, 5'd9};
    expect_val(K_D0, 32'h0, "rst2_d9");
    expect_val(K_D1, 32'h0, "rst2_d10");
    check_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised integer register file with NRD combinational read ports and one write port.
- Registers location 0 as hardwired zero.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard for in-flight writes.
- Sits between decode/issue (read ports, issue marking) and writeback (write port) in the core pipeline; lets issue stall on RAW hazards without external tracking.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers including register 0; power of two, minimum 2.
- NRD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads return stored value only.
- AW, $clog2(NREGS), derived address width; not overridden.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- rd_addr_i  in  NRD*AW  read addresses, port k at bits [k*AW +: AW].
- rd_data_o  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN].
- rd_busy_o  out  NRD  port k's register has an outstanding write.
- wr_en_i  in  1  writeback enable.
- wr_addr_i  in  AW  writeback destination.
- wr_data_i  in  XLEN  writeback data.
- iss_en_i  in  1  issue of an instruction that will write iss_addr_i.
- iss_addr_i  in  AW  destination being marked busy.
- flush_i  in  1  clear all busy bits (pipeline flush); register contents unaffected.
- busy_cnt_o  out  AW+1  number of registers currently busy.

Behaviour:
- Storage: regs[1..NREGS-1], XLEN each; busy[1..NREGS-1]; busy_cnt register. No storage for register 0.
- Reset (rst_i=1 at clk edge): all regs <= 0, all busy <= 0, busy_cnt <= 0. rst_i has priority over wr_en_i, iss_en_i and flush_i in that cycle.
- After reset, with no other activity: rd_data_o = 0, rd_busy_o = 0, busy_cnt_o = 0.
- Write: wr_en_i=1 and wr_addr_i!=0 -> regs[wr_addr_i] <= wr_data_i at the edge. Writes to 0 are dropped.
- Read: combinational, zero latency.
  - rd_addr=0 -> data 0, busy 0, always.
  - Otherwise, BYPASS=1 and wr_en_i=1 and wr_addr_i==rd_addr -> data = wr_data_i.
  - Otherwise -> data = regs[rd_addr].
  - All NRD ports are independent; identical addresses on several ports are legal and return identical data.
- rd_busy_o[k] = busy[a] & ~(wr_en_i & wr_addr_i==a), for a = rd_addr port k.
  - The writeback clear is visible in the same cycle only when BYPASS=1.
  - When BYPASS=0, rd_busy_o[k] = busy[a].
- Scoreboard next-state per register r != 0, priority highest first:
  1. flush_i=1 -> busy[r] <= 0 for all r. Issue in the same cycle is ignored.
  2. iss_en_i=1 and iss_addr_i==r -> busy[r] <= 1. Set wins over a same-cycle writeback clear: the newer producer.
  3. wr_en_i=1 and wr_addr_i==r -> busy[r] <= 0.
  4. Otherwise hold.
- iss_addr_i=0 never sets busy. Issuing to an already-busy register keeps it busy: single bit, no count per register.
- Writeback to a non-busy register is legal: data is written, busy stays 0.
- busy_cnt_o is registered and always equals the popcount of busy[] as of the last edge. It is updated with the scoreboard each cycle (recompute or +1/-1/0 delta; must match popcount). Range 0..NREGS-1.
- Reset asserted while busy bits are set or a write is in flight: all state cleared, and the in-flight write is lost.
- No X propagation: out-of-range addresses cannot occur (NREGS is a power of two).

Test Plan:
- Reset then read: rst_i=1 for 1 cycle, rd_addr = {5, 0} -> rd_data_o = 0 on both ports, rd_busy_o = 0, busy_cnt_o = 0.
- Write/read with bypass: wr_en=1, wr_addr=7, wr_data=0xDEADBEEF, rd_addr0=7 in the same cycle.
  - Same cycle: rd_data0 = 0xDEADBEEF.
  - Next cycle, wr_en=0: rd_data0 = 0xDEADBEEF.
  - With BYPASS=0: the first cycle returns the old value 0.
- x0 immunity: wr_en=1, wr_addr=0, wr_data=0x12345678, iss_en=1, iss_addr=0 -> rd_data for address 0 = 0 same and next cycle; busy_cnt_o stays 0.
- Scoreboard RAW sequence:
  - Issue 3 -> next cycle rd_busy for address 3 = 1, busy_cnt=1.
  - Issue 4 -> busy_cnt=2.
  - Writeback 3 with 0xA5 -> same cycle rd_busy(3)=0 and data 0xA5; next cycle busy_cnt=1.
- Simultaneous set/clear: busy[9]=1, then in one cycle iss_en with iss_addr=9 and wr_en with wr_addr=9, data 0x55 -> next cycle busy[9]=1, regs[9]=0x55, busy_cnt unchanged.
- Flush and mid-operation reset:
  - Busy {2, 5, 6}, flush_i=1 together with iss_addr=8 -> next cycle busy_cnt=0 and register 8 not busy; register data retained.
  - Repeat with rst_i=1 instead -> all data reads 0.
